// File: rtl/stu_pe_result_arbiter.sv
// stu_pe_result_arbiter
// Round-robin packet arbiter on the upstream stack bus. Each PE upstream port
// feeds a small FIFO. Whole packets are forwarded from the FIFOs to a single
// registered output without interleaving.
// Ports:
//   clk, reset_poweron        : clock, asynchronous active-high reset
//   pe__stu__valid/cntl/type/data/oob_data : per-PE input flits (PE i = slice i)
//   stu__pe__ready            : per-PE FIFO not full
//   stu__mgr__valid/cntl/type/data/oob_data/pe_id : output flit register
//   mgr__stu__ready           : downstream accepts the output flit
//   stu__sys__proto_error     : sticky packet framing error
module stu_pe_result_arbiter #(
  parameter int unsigned NUM_PE     = 4,
  parameter int unsigned TYPE_W     = 2,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned OOB_W      = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset_poweron,
  input  logic [NUM_PE-1:0]           pe__stu__valid,
  input  logic [2*NUM_PE-1:0]         pe__stu__cntl,
  input  logic [TYPE_W*NUM_PE-1:0]    pe__stu__type,
  input  logic [DATA_W*NUM_PE-1:0]    pe__stu__data,
  input  logic [OOB_W*NUM_PE-1:0]     pe__stu__oob_data,
  output logic [NUM_PE-1:0]           stu__pe__ready,
  output logic                        stu__mgr__valid,
  output logic [1:0]                  stu__mgr__cntl,
  output logic [TYPE_W-1:0]           stu__mgr__type,
  output logic [DATA_W-1:0]           stu__mgr__data,
  output logic [OOB_W-1:0]            stu__mgr__oob_data,
  output logic [$clog2(NUM_PE)-1:0]   stu__mgr__pe_id,
  input  logic                        mgr__stu__ready,
  output logic                        stu__sys__proto_error
);

  localparam int unsigned PID_W = $clog2(NUM_PE);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = AW + 1;

  localparam logic [1:0] CNTL_MOM     = 2'b00;
  localparam logic [1:0] CNTL_SOM     = 2'b01;
  localparam logic [1:0] CNTL_EOM     = 2'b10;
  localparam logic [1:0] CNTL_SOM_EOM = 2'b11;

  typedef struct packed {
    logic [1:0]        cntl;
    logic [TYPE_W-1:0] typ;
    logic [DATA_W-1:0] data;
    logic [OOB_W-1:0]  oob;
  } flit_t;

  typedef enum logic {IDLE, LOCKED} state_t;

  flit_t             in_flit [NUM_PE];
  flit_t             head    [NUM_PE];
  flit_t             mem     [NUM_PE][FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr  [NUM_PE];
  logic [AW-1:0]     rd_ptr  [NUM_PE];
  logic [CW-1:0]     count   [NUM_PE];
  logic [NUM_PE-1:0] push, pop, empty;

  state_t            state, state_nxt;
  logic [PID_W-1:0]  owner, owner_nxt, rr_ptr, rr_nxt;
  logic              err_set, can_load, load, found;
  logic [PID_W-1:0]  sel, cand, load_id;
  int unsigned       idx;
  flit_t             load_flit;

  function automatic logic [PID_W-1:0] next_port(input logic [PID_W-1:0] p);
    return (32'(p) == NUM_PE - 1) ? '0 : p + PID_W'(1);
  endfunction

  // Input unpacking, FIFO status and ready (from registered count)
  always_comb begin
    for (int i = 0; i < NUM_PE; i++) begin
      in_flit[i].cntl   = pe__stu__cntl[2*i +: 2];
      in_flit[i].typ    = pe__stu__type[TYPE_W*i +: TYPE_W];
      in_flit[i].data   = pe__stu__data[DATA_W*i +: DATA_W];
      in_flit[i].oob    = pe__stu__oob_data[OOB_W*i +: OOB_W];
      stu__pe__ready[i] = (count[i] != CW'(FIFO_DEPTH));
      push[i]           = pe__stu__valid[i] & stu__pe__ready[i];
      empty[i]          = (count[i] == '0);
      head[i]           = mem[i][rd_ptr[i]];
    end
  end

  // FIFO storage (no reset needed; count gates validity)
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PE; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= in_flit[i];
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      for (int i = 0; i < NUM_PE; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PE; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
        count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
      end
    end
  end

  // Grant / packet-lock next-state logic
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    rr_nxt    = rr_ptr;
    err_set   = 1'b0;
    pop       = '0;
    load      = 1'b0;
    load_id   = owner;
    load_flit = '0;
    found     = 1'b0;
    sel       = '0;
    cand      = '0;
    idx       = 0;
    can_load  = !stu__mgr__valid || mgr__stu__ready;

    case (state)
      IDLE: begin
        for (int unsigned k = 0; k < NUM_PE; k++) begin
          idx = 32'(rr_ptr) + k;
          if (idx >= NUM_PE) idx = idx - NUM_PE;
          cand = PID_W'(idx);
          if (!found && !empty[cand]) begin
            found = 1'b1;
            sel   = cand;
          end
        end
        if (found) begin
          case (head[sel].cntl)
            CNTL_SOM: begin
              if (can_load) begin
                pop[sel]  = 1'b1;
                load      = 1'b1;
                load_flit = head[sel];
                load_id   = sel;
                owner_nxt = sel;
                state_nxt = LOCKED;
              end
            end
            CNTL_SOM_EOM: begin
              if (can_load) begin
                pop[sel]  = 1'b1;
                load      = 1'b1;
                load_flit = head[sel];
                load_id   = sel;
                owner_nxt = sel;
                rr_nxt    = next_port(sel);
              end
            end
            // Continuation flit without a packet start: discard it
            default: begin
              pop[sel] = 1'b1;
              err_set  = 1'b1;
            end
          endcase
        end
      end
      LOCKED: begin
        if (can_load && !empty[owner]) begin
          pop[owner] = 1'b1;
          load       = 1'b1;
          load_flit  = head[owner];
          load_id    = owner;
          case (head[owner].cntl)
            CNTL_EOM: begin
              state_nxt = IDLE;
              rr_nxt    = next_port(owner);
            end
            CNTL_SOM, CNTL_SOM_EOM: err_set = 1'b1;
            default: ;
          endcase
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM and arbitration state
  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      state                 <= IDLE;
      owner                 <= '0;
      rr_ptr                <= '0;
      stu__sys__proto_error <= 1'b0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_nxt;
      if (err_set) stu__sys__proto_error <= 1'b1;
    end
  end

  // Output register: updates only when empty or being consumed
  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      stu__mgr__valid    <= 1'b0;
      stu__mgr__cntl     <= '0;
      stu__mgr__type     <= '0;
      stu__mgr__data     <= '0;
      stu__mgr__oob_data <= '0;
      stu__mgr__pe_id    <= '0;
    end else if (can_load) begin
      stu__mgr__valid <= load;
      if (load) begin
        stu__mgr__cntl     <= load_flit.cntl;
        stu__mgr__type     <= load_flit.typ;
        stu__mgr__data     <= load_flit.data;
        stu__mgr__oob_data <= load_flit.oob;
        stu__mgr__pe_id    <= load_id;
      end
    end
  end

endmodule
